// File: rtl/pcie_tlp_rx_router.sv
// pcie_tlp_rx_router
//
// Purpose: takes the dword-ordered TLP receive stream (header DW0 in
// data[255:224]). It decodes each TLP from its start-of-packet beat and steers
// the whole packet to the memory-request port or the completion port. Every
// other TLP type is discarded. Each output port has a one-entry register, so
// an accepted beat appears on its port one cycle later.
//
// Ports:
//   clk, reset_n         clock; asynchronous active-low reset
//   in_st_*              input stream (data 256, empty 5, sop, eop, error, valid)
//   in_st_ready          backpressure; depends only on the output readies
//   req_st_*             memory request stream (MRd/MWr) plus req_st_ready
//   cpl_st_*             completion stream (Cpl/CplD) plus cpl_st_ready
//   stat_*_count         saturating packet counters
//
// Configuration macro:
//   PCIE_TLP_RX_ROUTER_STATS_EN  defined   -> counters implemented
//                                undefined -> stat_* tied to zero
module pcie_tlp_rx_router (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [255:0] in_st_data,
   input  logic [4:0]   in_st_empty,
   input  logic         in_st_startofpacket,
   input  logic         in_st_endofpacket,
   input  logic         in_st_error,
   input  logic         in_st_valid,
   output logic         in_st_ready,
   output logic [255:0] req_st_data,
   output logic [4:0]   req_st_empty,
   output logic         req_st_startofpacket,
   output logic         req_st_endofpacket,
   output logic         req_st_error,
   output logic         req_st_valid,
   input  logic         req_st_ready,
   output logic [255:0] cpl_st_data,
   output logic [4:0]   cpl_st_empty,
   output logic         cpl_st_startofpacket,
   output logic         cpl_st_endofpacket,
   output logic         cpl_st_error,
   output logic         cpl_st_valid,
   input  logic         cpl_st_ready,
   output logic [31:0]  stat_req_count,
   output logic [31:0]  stat_cpl_count,
   output logic [31:0]  stat_drop_count
);

   typedef enum logic [1:0] {IDLE, FWD_REQ, FWD_CPL, DROP} state_t;
   typedef enum logic [1:0] {DST_NONE, DST_REQ, DST_CPL, DST_DROP} dest_t;

   state_t      state, state_nxt;
   dest_t       sop_dest, beat_dest;
   logic        accept;
   logic [2:0]  tlp_fmt;
   logic [4:0]  tlp_type;

   // Every beat, dropped ones included, waits for both ports so ordering
   // stays strictly in-line.
   assign in_st_ready = (!req_st_valid | req_st_ready) & (!cpl_st_valid | cpl_st_ready);
   assign accept      = in_st_valid & in_st_ready;

   assign tlp_fmt  = in_st_data[255:253];
   assign tlp_type = in_st_data[252:248];

   always_comb begin
      sop_dest = DST_DROP;
      if (tlp_type == 5'b00000 && !tlp_fmt[2])
         sop_dest = DST_REQ;
      else if (tlp_type == 5'b01010 && (tlp_fmt == 3'b000 || tlp_fmt == 3'b010))
         sop_dest = DST_CPL;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // An SOP is decoded in any state. A packet already in flight is simply
   // abandoned, which lets the adapter recover from a lost EOP.
   always_comb begin
      state_nxt = state;
      beat_dest = DST_NONE;
      if (accept) begin
         if (in_st_startofpacket) begin
            beat_dest = sop_dest;
            if (in_st_endofpacket)
               state_nxt = IDLE;
            else begin
               unique case (sop_dest)
                  DST_REQ: state_nxt = FWD_REQ;
                  DST_CPL: state_nxt = FWD_CPL;
                  default: state_nxt = DROP;
               endcase
            end
         end else begin
            unique case (state)
               FWD_REQ: beat_dest = DST_REQ;
               FWD_CPL: beat_dest = DST_CPL;
               default: beat_dest = DST_DROP;
            endcase
            if (in_st_endofpacket)
               state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_st_valid         <= 1'b0;
         req_st_data          <= '0;
         req_st_empty         <= '0;
         req_st_startofpacket <= 1'b0;
         req_st_endofpacket   <= 1'b0;
         req_st_error         <= 1'b0;
      end else if (beat_dest == DST_REQ) begin
         req_st_valid         <= 1'b1;
         req_st_data          <= in_st_data;
         req_st_empty         <= in_st_empty;
         req_st_startofpacket <= in_st_startofpacket;
         req_st_endofpacket   <= in_st_endofpacket;
         req_st_error         <= in_st_error;
      end else if (req_st_ready) begin
         req_st_valid         <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cpl_st_valid         <= 1'b0;
         cpl_st_data          <= '0;
         cpl_st_empty         <= '0;
         cpl_st_startofpacket <= 1'b0;
         cpl_st_endofpacket   <= 1'b0;
         cpl_st_error         <= 1'b0;
      end else if (beat_dest == DST_CPL) begin
         cpl_st_valid         <= 1'b1;
         cpl_st_data          <= in_st_data;
         cpl_st_empty         <= in_st_empty;
         cpl_st_startofpacket <= in_st_startofpacket;
         cpl_st_endofpacket   <= in_st_endofpacket;
         cpl_st_error         <= in_st_error;
      end else if (cpl_st_ready) begin
         cpl_st_valid         <= 1'b0;
      end
   end

`ifdef PCIE_TLP_RX_ROUTER_STATS_EN
   logic [31:0] req_cnt, cpl_cnt, drop_cnt;
   logic        req_inc, cpl_inc, drop_inc;

   // Packets count on their SOP beat. An orphan beat (no SOP seen while
   // idle) counts as one drop per beat.
   assign req_inc  = accept & in_st_startofpacket & (sop_dest == DST_REQ);
   assign cpl_inc  = accept & in_st_startofpacket & (sop_dest == DST_CPL);
   assign drop_inc = accept & ((in_st_startofpacket & (sop_dest == DST_DROP)) |
                               (!in_st_startofpacket & (state == IDLE)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_cnt  <= '0;
         cpl_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (req_inc && req_cnt != '1)
            req_cnt <= req_cnt + 32'd1;
         if (cpl_inc && cpl_cnt != '1)
            cpl_cnt <= cpl_cnt + 32'd1;
         if (drop_inc && drop_cnt != '1)
            drop_cnt <= drop_cnt + 32'd1;
      end
   end

   assign stat_req_count  = req_cnt;
   assign stat_cpl_count  = cpl_cnt;
   assign stat_drop_count = drop_cnt;
`else
   assign stat_req_count  = '0;
   assign stat_cpl_count  = '0;
   assign stat_drop_count = '0;
`endif

endmodule

// File: tb/tb_pcie_tlp_rx_router.sv
// Testbench for pcie_tlp_rx_router: directed scenarios followed by random
// traffic. Results are compared against a packet-level reference model.
module tb_pcie_tlp_rx_router;

   typedef struct packed {
      logic [255:0] d;
      logic [4:0]   e;
      logic         s;
      logic         eo;
      logic         er;
   } beat_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [255:0] in_st_data;
   logic [4:0]   in_st_empty;
   logic         in_st_startofpacket, in_st_endofpacket, in_st_error, in_st_valid;
   logic         in_st_ready;
   logic [255:0] req_st_data, cpl_st_data;
   logic [4:0]   req_st_empty, cpl_st_empty;
   logic         req_st_startofpacket, req_st_endofpacket, req_st_error, req_st_valid, req_st_ready;
   logic         cpl_st_startofpacket, cpl_st_endofpacket, cpl_st_error, cpl_st_valid, cpl_st_ready;
   logic [31:0]  stat_req_count, stat_cpl_count, stat_drop_count;

   pcie_tlp_rx_router dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .in_st_data           (in_st_data),
      .in_st_empty          (in_st_empty),
      .in_st_startofpacket  (in_st_startofpacket),
      .in_st_endofpacket    (in_st_endofpacket),
      .in_st_error          (in_st_error),
      .in_st_valid          (in_st_valid),
      .in_st_ready          (in_st_ready),
      .req_st_data          (req_st_data),
      .req_st_empty         (req_st_empty),
      .req_st_startofpacket (req_st_startofpacket),
      .req_st_endofpacket   (req_st_endofpacket),
      .req_st_error         (req_st_error),
      .req_st_valid         (req_st_valid),
      .req_st_ready         (req_st_ready),
      .cpl_st_data          (cpl_st_data),
      .cpl_st_empty         (cpl_st_empty),
      .cpl_st_startofpacket (cpl_st_startofpacket),
      .cpl_st_endofpacket   (cpl_st_endofpacket),
      .cpl_st_error         (cpl_st_error),
      .cpl_st_valid         (cpl_st_valid),
      .cpl_st_ready         (cpl_st_ready),
      .stat_req_count       (stat_req_count),
      .stat_cpl_count       (stat_cpl_count),
      .stat_drop_count      (stat_drop_count)
   );

   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   // Reference model. Packet destination: 0 = none in flight, 1 = req,
   // 2 = cpl, 3 = discard.
   int          m_cur;
   logic        m_req_v, m_cpl_v;
   beat_t       m_req, m_cpl;
   logic [31:0] m_nreq, m_ncpl, m_ndrop;

   function automatic int classify(input logic [31:0] dw0);
      logic [2:0] f;
      logic [4:0] t;
      f = dw0[31:29];
      t = dw0[28:24];
      if (t == 5'd0 && f < 3'd4) return 1;
      if (t == 5'd10 && (f == 3'd0 || f == 3'd2)) return 2;
      return 3;
   endfunction

   function automatic logic [31:0] sat1(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   function automatic logic [31:0] xs(input logic [31:0] c);
`ifdef PCIE_TLP_RX_ROUTER_STATS_EN
      return c;
`else
      return (c & 32'd0);
`endif
   endfunction

   task automatic model_reset();
      m_cur   = 0;
      m_req_v = 1'b0;
      m_cpl_v = 1'b0;
      m_req   = '0;
      m_cpl   = '0;
      m_nreq  = '0;
      m_ncpl  = '0;
      m_ndrop = '0;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_outputs();
      chk("req_valid", 256'(req_st_valid), 256'(m_req_v));
      chk("cpl_valid", 256'(cpl_st_valid), 256'(m_cpl_v));
      if (m_req_v) begin
         chk("req_data", req_st_data, m_req.d);
         chk("req_ctl", {req_st_empty, req_st_startofpacket, req_st_endofpacket, req_st_error},
             {m_req.e, m_req.s, m_req.eo, m_req.er});
      end
      if (m_cpl_v) begin
         chk("cpl_data", cpl_st_data, m_cpl.d);
         chk("cpl_ctl", {cpl_st_empty, cpl_st_startofpacket, cpl_st_endofpacket, cpl_st_error},
             {m_cpl.e, m_cpl.s, m_cpl.eo, m_cpl.er});
      end
      chk("stat_req", 256'(stat_req_count), 256'(xs(m_nreq)));
      chk("stat_cpl", 256'(stat_cpl_count), 256'(xs(m_ncpl)));
      chk("stat_drop", 256'(stat_drop_count), 256'(xs(m_ndrop)));
   endtask

   // One clock cycle: entered just after a falling edge and left at the next one.
   task automatic step(input logic v, input logic sop, input logic eop,
                       input logic [255:0] d, input logic [4:0] e, input logic er,
                       input logic rr, input logic cr, output logic acc);
      logic  exp_rdy;
      int    dest;
      beat_t b;
      in_st_valid         = v;
      in_st_startofpacket = sop;
      in_st_endofpacket   = eop;
      in_st_data          = d;
      in_st_empty         = e;
      in_st_error         = er;
      req_st_ready        = rr;
      cpl_st_ready        = cr;
      #1;
      exp_rdy = (!m_req_v || rr) && (!m_cpl_v || cr);
      chk("in_ready", 256'(in_st_ready), 256'(exp_rdy));
      acc  = v & exp_rdy;
      dest = 0;
      b    = '{d: d, e: e, s: sop, eo: eop, er: er};
      if (acc) begin
         if (sop) begin
            dest = classify(d[255:224]);
            if (dest == 1) m_nreq = sat1(m_nreq);
            else if (dest == 2) m_ncpl = sat1(m_ncpl);
            else m_ndrop = sat1(m_ndrop);
            m_cur = eop ? 0 : dest;
         end else if (m_cur == 0) begin
            dest    = 3;
            m_ndrop = sat1(m_ndrop);
         end else begin
            dest = m_cur;
            if (eop) m_cur = 0;
         end
      end
      if (dest == 1) begin m_req_v = 1'b1; m_req = b; end
      else if (rr) m_req_v = 1'b0;
      if (dest == 2) begin m_cpl_v = 1'b1; m_cpl = b; end
      else if (cr) m_cpl_v = 1'b0;
      @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] with_hdr(input logic [255:0] body, input logic [31:0] dw0);
      logic [255:0] r;
      r = body;
      r[255:224] = dw0;
      return r;
   endfunction

   logic [31:0] hdrs [12] = '{32'h4000_0004, 32'h0000_0001, 32'h2000_0002, 32'h6000_0010,
                              32'h4A00_0001, 32'h0A00_0000, 32'h3000_0000, 32'h0400_0001,
                              32'h8A00_0000, 32'h8000_0000, 32'h6A00_0000, 32'h4B00_0000};

   logic acc;

   initial begin
      logic [255:0] d;
      logic         g_in_pkt, have, v, sop, eop, er, rr, cr;
      logic [4:0]   e;

      reset_n             = 1'b0;
      in_st_valid         = 1'b0;
      in_st_startofpacket = 1'b0;
      in_st_endofpacket   = 1'b0;
      in_st_data          = '0;
      in_st_empty         = '0;
      in_st_error         = 1'b0;
      req_st_ready        = 1'b1;
      cpl_st_ready        = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Reset state
      chk("rst_in_ready", 256'(in_st_ready), 256'(1'b1));
      chk("rst_req_data", req_st_data, '0);
      chk("rst_cpl_data", cpl_st_data, '0);
      check_outputs();

      // 3DW MWr, two beats, empty 16 on EOP
      step(1, 1, 0, with_hdr(rnd256(), 32'h4000_0004), 5'd0, 0, 1, 1, acc);
      chk("mwr_sop_out", 256'({req_st_valid, req_st_startofpacket}), 256'(2'b11));
      step(1, 0, 1, rnd256(), 5'd16, 0, 1, 1, acc);
      chk("mwr_eop_empty", 256'(req_st_empty), 256'(5'd16));
      chk("mwr_cpl_idle", 256'(cpl_st_valid), 256'(1'b0));
      chk("mwr_req_cnt", 256'(stat_req_count), 256'(xs(32'd1)));

      // Single-beat CplD
      step(1, 1, 1, with_hdr(rnd256(), 32'h4A00_0001), 5'd4, 0, 1, 1, acc);
      chk("cpld_out", 256'({cpl_st_valid, cpl_st_startofpacket, cpl_st_endofpacket}), 256'(3'b111));
      chk("cpld_cnt", 256'(stat_cpl_count), 256'(xs(32'd1)));

      // Message TLP, three beats, discarded
      step(1, 1, 0, with_hdr(rnd256(), 32'h3000_0000), 5'd0, 0, 1, 1, acc);
      step(1, 0, 0, rnd256(), 5'd0, 0, 1, 1, acc);
      step(1, 0, 1, rnd256(), 5'd8, 0, 1, 1, acc);
      chk("msg_drop_cnt", 256'(stat_drop_count), 256'(xs(32'd1)));
      chk("msg_no_out", 256'({req_st_valid, cpl_st_valid}), 256'(2'b00));

      // MWr stalled by req_st_ready low for five cycles
      step(1, 1, 0, with_hdr(rnd256(), 32'h6000_0000), 5'd0, 0, 1, 1, acc);
      d = rnd256();
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, d, 5'd0, 0, 0, 1, acc);
         chk("stall_acc", 256'(acc), 256'(1'b0));
      end
      step(1, 0, 0, d, 5'd0, 0, 1, 1, acc);
      chk("stall_release", 256'(acc), 256'(1'b1));
      step(1, 0, 1, rnd256(), 5'd12, 1, 1, 1, acc);
      step(0, 0, 0, '0, 5'd0, 0, 1, 1, acc);

      // Reset mid-packet, then a non-SOP tail and a CplD
      step(1, 1, 0, with_hdr(rnd256(), 32'h4000_0001), 5'd0, 0, 0, 1, acc);
      reset_n = 1'b0;
      #1;
      chk("async_rst_out", 256'({req_st_valid, cpl_st_valid, stat_req_count}), '0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      step(1, 0, 0, rnd256(), 5'd0, 0, 1, 1, acc);
      step(1, 0, 1, rnd256(), 5'd4, 0, 1, 1, acc);
      chk("tail_drop_cnt", 256'(stat_drop_count), 256'(xs(32'd2)));
      step(1, 1, 1, with_hdr(rnd256(), 32'h4A00_0002), 5'd0, 0, 1, 1, acc);
      chk("post_rst_cpl", 256'({cpl_st_valid, req_st_valid}), 256'(2'b10));

      // Random traffic: legal packets mixed with orphans and abandoned packets
      g_in_pkt = 1'b0;
      have     = 1'b0;
      v = 0; sop = 0; eop = 0; er = 0; e = '0; d = '0;
      for (int n = 0; n < 3000; n++) begin
         if (!have) begin
            v   = ($urandom % 8) != 0;
            sop = g_in_pkt ? (($urandom % 25) == 0) : (($urandom % 20) != 0);
            eop = ($urandom % 3) == 0;
            e   = 5'(($urandom % 8) * 4);
            er  = ($urandom % 16) == 0;
            d   = rnd256();
            if (sop) d = with_hdr(d, hdrs[$urandom % 12]);
         end
         rr = ($urandom % 4) != 0;
         cr = ($urandom % 4) != 0;
         step(v, sop, eop, d, e, er, rr, cr, acc);
         have = v & !acc;
         if (acc) begin
            if (sop) g_in_pkt = !eop;
            else if (eop) g_in_pkt = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pcie_tlp_rx_router.md
# pcie_tlp_rx_router

Consumes the dword-ordered TLP receive stream from the PCIe TLP adapter, where header DW0 sits in data[255:224]. Decodes each TLP's header on its start-of-packet beat. Steers the whole packet to a memory-request output or a completion output, and discards every other TLP type. A registered output stage gives one cycle of latency, and optional statistics counters support debug.

## Interface
- No parameters; data width fixed at 256 bits, empty at 5 bits.
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- in_st_data / in_st_empty / in_st_startofpacket / in_st_endofpacket / in_st_error / in_st_valid  in  256/5/1/1/1/1  TLP stream from adapter; empty in bytes, multiple of 4
- in_st_ready  out  1  backpressure to adapter
- req_st_data / _empty / _startofpacket / _endofpacket / _error / _valid  out  256/5/1/1/1/1  memory request stream
- req_st_ready  in  1
- cpl_st_data / _empty / _startofpacket / _endofpacket / _error / _valid  out  256/5/1/1/1/1  completion stream
- cpl_st_ready  in  1
- stat_req_count, stat_cpl_count, stat_drop_count  out  32 each  packet counters

## Operation
- Decoding uses the SOP beat only:
  - fmt = data[255:253], type = data[252:248].
  - type 5'b00000 with fmt[2]==0 → REQ (MRd/MWr, 3DW or 4DW).
  - type 5'b01010 with fmt in {000, 010} → CPL (Cpl/CplD).
  - Anything else → DROP.
- State machine: IDLE, FWD_REQ, FWD_CPL, DROP.
  - IDLE:
    - An accepted beat with SOP and EOP forwards or drops in place and stays in IDLE.
    - An accepted beat with SOP but no EOP moves to FWD_REQ, FWD_CPL or DROP.
    - An accepted beat without SOP is an orphan: discarded, counted as a drop, stays in IDLE.
  - FWD_x: forwards every accepted beat to port x. The accepted EOP beat returns to IDLE.
  - DROP: discards beats. The accepted EOP beat returns to IDLE.
  - SOP while not in IDLE: the in-flight packet is abandoned. The beat is re-decoded as a new packet. The last beat already emitted on the abandoned port is not patched. Only the new packet is counted.
- Each output port has a one-entry register: valid, data, empty, sop, eop, error.
  - A port's register loads when a beat is routed to it.
  - It clears when the port's ready is high and no new beat loads.
- in_st_ready = (!req_valid | req_st_ready) & (!cpl_valid | cpl_st_ready).
  - Combinational from output readies only, never from in_st_valid. Ready latency 0.
- Dropped beats still need in_st_ready high. This keeps ordering strictly in-line.
- empty and error are copied unchanged. empty is meaningful only on EOP beats and forwarded as-is on others.
- Counters are incremented when the SOP beat is accepted:
  - req or cpl count for routed packets.
  - drop count for dropped packets and orphan beats.
  - All counters saturate at 32'hFFFFFFFF.

## Timing
- Latency: beat accepted at edge N appears on the output at edge N+1.
- Throughput: one beat per cycle when both destination readies are held high.
- Reset values: all *_valid 0, sop/eop/error 0, data 0, empty 0, counters 0, state IDLE.
- in_st_ready follows the readies and is 1 after reset.
- Reset asserted mid-packet: outputs are cleared asynchronously. The partial packet is lost. After release, the block waits for the next SOP; earlier non-SOP beats are orphans.
- When one port stalls, the whole input stalls, including beats destined for the other port.

## Configuration
- PCIE_TLP_RX_ROUTER_STATS_EN defined: the three saturating 32-bit counters are implemented.
- Macro undefined: no counter flops; stat_* outputs are tied to 32'h0. Routing is identical.

## Test plan
- 3DW MWr, 2 beats, DW0=32'h4000_0004, EOP empty=5'd16 → 2 beats on req after 1 cycle, empty 16, stat_req_count=1, cpl idle.
- CplD, 1 beat, DW0=32'h4A00_0001, sop=eop=1 → single beat on cpl, stat_cpl_count=1.
- Message TLP (DW0=32'h3000_0000), 3 beats → nothing output, in_st_ready high throughout, stat_drop_count=1.
- MWr in flight with req_st_ready=0 for 5 cycles → in_st_ready=0 for those cycles; no beats lost or duplicated; cpl_valid stays 0.
- Reset_n pulsed low mid-FWD_REQ, then a 2-beat non-SOP tail followed by a CplD → tail dropped (drop count +2), CplD routed to cpl.
- Counter preset near saturation via 2^32+ packets (STATS_EN defined) → counter holds 32'hFFFFFFFF. Same bench without the macro → stat_* always 0.
